// File: rtl/writeback_arbiter_pkg.sv
// Shared write-back definitions: register-file geometry and the long-result queue entry.
package writeback_arbiter_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    // One queued long-latency result: destination register plus its value.
    typedef struct packed {
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Register $0 is hard-wired to zero and is never written or tracked.
    function automatic logic is_zero_reg(input logic [REG_W-1:0] r);
        return (r == '0);
    endfunction

endpackage

// File: rtl/writeback_arbiter_wb_fifo.sv
// Synchronous FIFO for long-latency results waiting for a register-file write slot.
// Push is ignored while full and pop is ignored while empty, so callers may
// drive them from their own request logic without extra guarding.
module wb_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  wb_entry_t                push_entry,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Entry storage needs no reset: contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Occupancy tracks push/pop at the same edge; push and pop together cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Write-back arbiter: sole driver of the register-file write port.
// Merges single-cycle pipeline results with queued long-latency results,
// tracks pending long writes in a scoreboard for decode hazard checks, and
// forces a pipeline stall when the long-result queue has waited too long.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int LQ_DEPTH     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pipe_valid,
    input  logic [4:0]                  pipe_reg,
    input  logic [31:0]                 pipe_data,
    output logic                        pipe_stall,
    input  logic                        long_issue,
    input  logic [4:0]                  long_issue_reg,
    input  logic                        long_valid,
    output logic                        long_ready,
    input  logic [4:0]                  long_reg,
    input  logic [31:0]                 long_data,
    input  logic [4:0]                  chk_reg1,
    input  logic [4:0]                  chk_reg2,
    output logic                        busy1,
    output logic                        busy2,
    output logic                        reg_write,
    output logic [4:0]                  write_reg,
    output logic [31:0]                 write_data,
    output logic [$clog2(LQ_DEPTH):0]   lq_count,
    output logic                        proto_err
);

    localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_LIMIT - 1);
    localparam logic [CNT_W-1:0] STARVE_ONE  = CNT_W'(1);

    logic [NUM_REGS-1:0] scoreboard;
    logic [NUM_REGS-1:0] sb_set;
    logic [NUM_REGS-1:0] sb_clr;
    logic [NUM_REGS-1:0] sb_next;
    logic [CNT_W-1:0]    starve_cnt;

    wb_entry_t head;
    wb_entry_t push_entry;
    logic      fifo_full;
    logic      fifo_empty;
    logic      push;
    logic      drain;
    logic      pipe_take;
    logic      blocked;
    logic      violation;

    // Queue of long results; arbitration decides when the head is popped.
    wb_fifo #(
        .DEPTH (LQ_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (drain),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (lq_count)
    );

    assign long_ready = !fifo_full;
    assign push       = long_valid && long_ready;
    assign push_entry = '{dest: long_reg, data: long_data};

    // A forced stall always favours the queue; otherwise the pipe wins and the
    // queue only drains in cycles where the pipe has nothing to write.
    assign drain     = !fifo_empty && (pipe_stall || !pipe_valid);
    assign pipe_take = pipe_valid && !pipe_stall;
    assign blocked   = !fifo_empty && !drain;

    assign busy1 = !is_zero_reg(chk_reg1) && scoreboard[chk_reg1];
    assign busy2 = !is_zero_reg(chk_reg2) && scoreboard[chk_reg2];

    // Protocol violations: pipe result offered during a stall, pipe WAW against
    // a pending long op, or a long result drained that was never issued.
    assign violation = (pipe_valid && pipe_stall)
                    || (pipe_valid && !is_zero_reg(pipe_reg) && scoreboard[pipe_reg])
                    || (drain && !is_zero_reg(head.dest) && !scoreboard[head.dest]);

    // Next scoreboard: clear the drained destination, then apply the new issue so set wins.
    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (long_issue && !is_zero_reg(long_issue_reg)) begin
            sb_set[long_issue_reg] = 1'b1;
        end
        if (drain) begin
            sb_clr[head.dest] = 1'b1;
        end
        sb_next = (scoreboard & ~sb_clr) | sb_set;
    end

    // Pending long-write scoreboard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scoreboard <= '0;
        end else begin
            scoreboard <= sb_next;
        end
    end

    // Count blocked queue cycles and raise a one-cycle stall on the last allowed one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            pipe_stall <= 1'b0;
        end else if (blocked) begin
            starve_cnt <= starve_cnt + STARVE_ONE;
            pipe_stall <= (starve_cnt == STARVE_LAST);
        end else begin
            starve_cnt <= '0;
            pipe_stall <= 1'b0;
        end
    end

    // Register the selected write; $0 destinations pop or pass without enabling the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else if (drain) begin
            reg_write  <= !is_zero_reg(head.dest);
            write_reg  <= head.dest;
            write_data <= head.data;
        end else if (pipe_take) begin
            reg_write  <= !is_zero_reg(pipe_reg);
            write_reg  <= pipe_reg;
            write_data <= pipe_data;
        end else begin
            reg_write  <= 1'b0;
        end
    end

    // Sticky protocol-error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
        end else if (violation) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed testbench for writeback_arbiter with hand-computed expectations.
module tb_writeback_arbiter;

    logic        clk;
    logic        rst_n;
    logic        pipe_valid;
    logic [4:0]  pipe_reg;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        long_issue;
    logic [4:0]  long_issue_reg;
    logic        long_valid;
    logic        long_ready;
    logic [4:0]  long_reg;
    logic [31:0] long_data;
    logic [4:0]  chk_reg1;
    logic [4:0]  chk_reg2;
    logic        busy1;
    logic        busy2;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [2:0]  lq_count;
    logic        proto_err;

    int errors = 0;
    int checks = 0;

    writeback_arbiter #(
        .LQ_DEPTH     (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pipe_valid     (pipe_valid),
        .pipe_reg       (pipe_reg),
        .pipe_data      (pipe_data),
        .pipe_stall     (pipe_stall),
        .long_issue     (long_issue),
        .long_issue_reg (long_issue_reg),
        .long_valid     (long_valid),
        .long_ready     (long_ready),
        .long_reg       (long_reg),
        .long_data      (long_data),
        .chk_reg1       (chk_reg1),
        .chk_reg2       (chk_reg2),
        .busy1          (busy1),
        .busy2          (busy2),
        .reg_write      (reg_write),
        .write_reg      (write_reg),
        .write_data     (write_data),
        .lq_count       (lq_count),
        .proto_err      (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it in, then settle just after the edge.
    task automatic applyStimulus(input logic pv, input logic [4:0] preg, input logic [31:0] pdata,
                                 input logic li, input logic [4:0] lireg,
                                 input logic lv, input logic [4:0] lreg, input logic [31:0] ldata);
        pipe_valid     = pv;
        pipe_reg       = preg;
        pipe_data      = pdata;
        long_issue     = li;
        long_issue_reg = lireg;
        long_valid     = lv;
        long_reg       = lreg;
        long_data      = ldata;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    endtask

    // Hold reset across an edge, then release it away from the active edge.
    task automatic doReset();
        pipe_valid = 1'b0; pipe_reg = '0; pipe_data = '0;
        long_issue = 1'b0; long_issue_reg = '0;
        long_valid = 1'b0; long_reg = '0; long_data = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        chk_reg1 = '0;
        chk_reg2 = '0;
        doReset();

        // Reset state
        checkOutput("rst_reg_write", 32'(reg_write), 32'd0);
        checkOutput("rst_write_reg", 32'(write_reg), 32'd0);
        checkOutput("rst_write_data", write_data, 32'd0);
        checkOutput("rst_pipe_stall", 32'(pipe_stall), 32'd0);
        checkOutput("rst_lq_count", 32'(lq_count), 32'd0);
        checkOutput("rst_long_ready", 32'(long_ready), 32'd1);
        checkOutput("rst_proto_err", 32'(proto_err), 32'd0);

        // Single pipe write, one-cycle latency
        applyStimulus(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        checkOutput("pipe_reg_write", 32'(reg_write), 32'd1);
        checkOutput("pipe_write_reg", 32'(write_reg), 32'd5);
        checkOutput("pipe_write_data", write_data, 32'h1234_5678);
        idleCycle();
        checkOutput("pipe_idle_reg_write", 32'(reg_write), 32'd0);
        checkOutput("pipe_idle_hold_reg", 32'(write_reg), 32'd5);

        // Long op on reg 9: scoreboard set, result enqueued then written
        chk_reg1 = 5'd9;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0);
        checkOutput("long_busy_set", 32'(busy1), 32'd1);
        idleCycle();
        idleCycle();
        checkOutput("long_ready_empty", 32'(long_ready), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd9, 32'hDEAD_BEEF);
        checkOutput("long_enq_count", 32'(lq_count), 32'd1);
        checkOutput("long_enq_no_write", 32'(reg_write), 32'd0);
        checkOutput("long_busy_held", 32'(busy1), 32'd1);
        idleCycle();
        checkOutput("long_reg_write", 32'(reg_write), 32'd1);
        checkOutput("long_write_reg", 32'(write_reg), 32'd9);
        checkOutput("long_write_data", write_data, 32'hDEAD_BEEF);
        checkOutput("long_busy_clear", 32'(busy1), 32'd0);
        checkOutput("long_count_empty", 32'(lq_count), 32'd0);
        checkOutput("long_proto_err", 32'(proto_err), 32'd0);

        // Fill the queue while the pipe writes every cycle, then starve-stall
        doReset();
        for (int r = 10; r < 14; r++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'(r), 1'b0, 5'd0, 32'h0);
        end
        for (int r = 10; r < 14; r++) begin
            applyStimulus(1'b1, 5'd1, 32'h0000_0100 + 32'(r), 1'b0, 5'd0, 1'b1, 5'(r), 32'hA000_0000 + 32'(r));
        end
        checkOutput("fill_lq_count", 32'(lq_count), 32'd4);
        checkOutput("fill_long_ready", 32'(long_ready), 32'd0);
        checkOutput("fill_pipe_write", 32'(write_reg), 32'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'd1, 32'h0000_0200, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
            checkOutput("starve_no_stall_yet", 32'(pipe_stall), 32'd0);
        end
        applyStimulus(1'b1, 5'd1, 32'h0000_0300, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        checkOutput("starve_stall", 32'(pipe_stall), 32'd1);
        checkOutput("starve_full_ready", 32'(long_ready), 32'd0);
        chk_reg1 = 5'd10;
        chk_reg2 = 5'd11;
        idleCycle();
        checkOutput("starve_stall_drop", 32'(pipe_stall), 32'd0);
        checkOutput("starve_reg_write", 32'(reg_write), 32'd1);
        checkOutput("starve_write_reg", 32'(write_reg), 32'd10);
        checkOutput("starve_write_data", write_data, 32'hA000_000A);
        checkOutput("starve_lq_count", 32'(lq_count), 32'd3);
        checkOutput("starve_ready_again", 32'(long_ready), 32'd1);
        checkOutput("starve_busy10", 32'(busy1), 32'd0);
        checkOutput("starve_busy11", 32'(busy2), 32'd1);
        checkOutput("starve_proto_err", 32'(proto_err), 32'd0);

        // Writes to $0 are suppressed but the queue still pops
        doReset();
        chk_reg1 = 5'd0;
        applyStimulus(1'b1, 5'd0, 32'h5555_5555, 1'b1, 5'd0, 1'b0, 5'd0, 32'h0);
        checkOutput("zero_pipe_no_write", 32'(reg_write), 32'd0);
        checkOutput("zero_busy", 32'(busy1), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd0, 32'h6666_6666);
        checkOutput("zero_enq_count", 32'(lq_count), 32'd1);
        idleCycle();
        checkOutput("zero_long_no_write", 32'(reg_write), 32'd0);
        checkOutput("zero_popped", 32'(lq_count), 32'd0);

        // Re-issue of reg 7 in the same cycle its old result drains: set wins
        doReset();
        chk_reg1 = 5'd7;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h0000_0777);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0);
        checkOutput("setwin_write_reg", 32'(write_reg), 32'd7);
        checkOutput("setwin_reg_write", 32'(reg_write), 32'd1);
        checkOutput("setwin_busy7", 32'(busy1), 32'd1);
        checkOutput("setwin_proto_err", 32'(proto_err), 32'd0);

        // Pipe write to a register with a pending long op flags WAW but still writes
        doReset();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b1, 5'd20, 32'h0BAD_0014, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        checkOutput("waw_reg_write", 32'(reg_write), 32'd1);
        checkOutput("waw_write_data", write_data, 32'h0BAD_0014);
        checkOutput("waw_proto_err", 32'(proto_err), 32'd1);
        idleCycle();
        checkOutput("waw_sticky", 32'(proto_err), 32'd1);

        // Asynchronous reset in the middle of a cycle with queued work
        doReset();
        chk_reg1 = 5'd3;
        chk_reg2 = 5'd4;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b1, 5'd1, 32'h0000_00C1, 1'b0, 5'd0, 1'b1, 5'd3, 32'h0000_0333);
        applyStimulus(1'b1, 5'd1, 32'h0000_00C2, 1'b0, 5'd0, 1'b1, 5'd4, 32'h0000_0444);
        checkOutput("mid_pre_count", 32'(lq_count), 32'd2);
        checkOutput("mid_pre_busy3", 32'(busy1), 32'd1);
        checkOutput("mid_pre_write", 32'(reg_write), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reg_write", 32'(reg_write), 32'd0);
        checkOutput("mid_write_reg", 32'(write_reg), 32'd0);
        checkOutput("mid_write_data", write_data, 32'd0);
        checkOutput("mid_lq_count", 32'(lq_count), 32'd0);
        checkOutput("mid_busy3", 32'(busy1), 32'd0);
        checkOutput("mid_busy4", 32'(busy2), 32'd0);
        pipe_valid = 1'b0;
        long_valid = 1'b0;
        long_issue = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idleCycle();
            checkOutput("post_rst_no_write", 32'(reg_write), 32'd0);
            checkOutput("post_rst_count", 32'(lq_count), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
